// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 matrix keypad scanner.
//   state_e   - scanner FSM states (column drive / sweep evaluation)
//   COLS_IDLE - column drive value with no column selected
//   KEYMAP    - hex key value at [row][col] of the keypad
//   key_onehot- hex key value to [0:15] one-hot key vector
package keypad_pkg;

    typedef enum logic {
        S_DRIVE = 1'b0,
        S_EVAL  = 1'b1
    } state_e;

    localparam logic [3:0] COLS_IDLE = 4'b1111;

    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    function automatic logic [0:15] key_onehot(input logic [3:0] key_val);
        logic [0:15] v;
        v          = '0;
        v[key_val] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad pins plus debounced key outputs.
//   rows       - keypad row lines, active-low (keypad -> scanner)
//   cols       - column drive, active-low, one column at a time (scanner -> keypad)
//   keys       - [0:15] debounced key state, bit n = hex key n held
//   key_strobe - one-cycle pulse when keys goes from 0 to nonzero
// slave modport: the scanner. master modport: keypad side / key consumer.
interface keypad_scanner_if;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [0:15] keys;
    logic        key_strobe;

    modport slave (
        input  rows,
        output cols,
        output keys,
        output key_strobe
    );

    modport master (
        output rows,
        input  cols,
        input  keys,
        input  key_strobe
    );
endinterface

// File: rtl/keypad_scanner_row_sync.sv
// row_sync: 4-bit two-flop synchroniser for the keypad row lines.
//   clk - system clock
//   res - asynchronous active-low reset; both stages reset to 4'b1111 (no key)
//   d   - asynchronous row inputs
//   q   - synchronised rows
module row_sync (
    input  logic       clk,
    input  logic       res,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] s1_q, s1_d;
    logic [3:0] s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces full
// sweeps and presents the single held key as a one-hot [0:15] vector.
//   clk - system clock
//   res - asynchronous active-low reset
//   bus - keypad_scanner_if.slave: rows in, cols / keys / key_strobe out
// Parameters:
//   COL_DWELL      - cycles each column is driven before sampling (>= 4)
//   DEBOUNCE_SCANS - identical consecutive sweeps needed to update keys (>= 1)
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned COL_DWELL      = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             res,
    keypad_scanner_if.slave  bus
);

    localparam int unsigned DW = $clog2(COL_DWELL);
    localparam int unsigned SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(COL_DWELL - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

    logic [3:0]    rows_sync;

    state_e        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [15:0]   snapshot_q, snapshot_d;
    logic [15:0]   prev_snapshot_q, prev_snapshot_d;
    logic [SW-1:0] stable_cnt_q, stable_cnt_d;
    logic [0:15]   keys_q, keys_d;
    logic          key_strobe_q, key_strobe_d;
    logic [3:0]    cols_q, cols_d;

    logic [4:0]    pop;
    logic [3:0]    hit_idx;
    logic [SW-1:0] stable_upd;

    row_sync u_row_sync (
        .clk (clk),
        .res (res),
        .d   (bus.rows),
        .q   (rows_sync)
    );

    // State register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q         <= S_DRIVE;
            col_q           <= '0;
            dwell_q         <= '0;
            snapshot_q      <= '0;
            prev_snapshot_q <= '0;
            stable_cnt_q    <= '0;
            keys_q          <= '0;
            key_strobe_q    <= 1'b0;
            cols_q          <= COLS_IDLE;
        end else begin
            state_q         <= state_d;
            col_q           <= col_d;
            dwell_q         <= dwell_d;
            snapshot_q      <= snapshot_d;
            prev_snapshot_q <= prev_snapshot_d;
            stable_cnt_q    <= stable_cnt_d;
            keys_q          <= keys_d;
            key_strobe_q    <= key_strobe_d;
            cols_q          <= cols_d;
        end
    end

    // Next state: column walk, dwell timing and per-column row sampling
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        dwell_d    = dwell_q;
        snapshot_d = snapshot_q;
        unique case (state_q)
            S_DRIVE: begin
                if (dwell_q == DWELL_LAST) begin
                    // snapshot bit index is {row, col}
                    for (int unsigned r = 0; r < 4; r++) begin
                        snapshot_d[{2'(r), col_q}] = ~rows_sync[r];
                    end
                    dwell_d = '0;
                    if (col_q == 2'd3) begin
                        col_d   = '0;
                        state_d = S_EVAL;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            S_EVAL: begin
                state_d = S_DRIVE;
            end
            default: begin
                state_d = S_DRIVE;
            end
        endcase
    end

    // Popcount of the completed sweep and position of its last set bit
    always_comb begin
        pop     = '0;
        hit_idx = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (snapshot_q[i]) begin
                pop     = pop + 5'd1;
                hit_idx = 4'(i);
            end
        end
    end

    // Debounce and key decode at the end of each sweep
    always_comb begin
        if (snapshot_q != prev_snapshot_q) begin
            stable_upd = SW'(1);
        end else if (stable_cnt_q == STABLE_MAX) begin
            stable_upd = STABLE_MAX;
        end else begin
            stable_upd = stable_cnt_q + 1'b1;
        end

        prev_snapshot_d = prev_snapshot_q;
        stable_cnt_d    = stable_cnt_q;
        keys_d          = keys_q;
        if (state_q == S_EVAL) begin
            prev_snapshot_d = snapshot_q;
            stable_cnt_d    = stable_upd;
            if (stable_upd == STABLE_MAX) begin
                // Two or more keys (incl. ghosts) leave keys unchanged
                if (pop == 5'd0) begin
                    keys_d = '0;
                end else if (pop == 5'd1) begin
                    keys_d = key_onehot(KEYMAP[hit_idx[3:2]][hit_idx[1:0]]);
                end
            end
        end
    end

    // Outputs. cols is registered from the current state, so the pin lags
    // the FSM by one cycle; each column still sees a full dwell of drive
    // and the idle cycle lines up with the keys update.
    always_comb begin
        cols_d       = (state_q == S_DRIVE) ? ~(4'b0001 << col_q) : COLS_IDLE;
        key_strobe_d = (keys_q == '0) && (keys_d != '0);
    end

    assign bus.cols       = cols_q;
    assign bus.keys       = keys_q;
    assign bus.key_strobe = key_strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed self-checking bench for keypad_scanner with
// COL_DWELL=8, DEBOUNCE_SCANS=3 (33-cycle sweep). A combinational keypad
// model pulls row r low while column c is driven low and key (r,c) is held.
module tb_keypad_scanner;

    logic clk;
    logic res;
    logic [15:0] pressed;   // bit r*4+c = key at row r, col c held

    int n_checks;
    int n_fail;
    int strobe_cnt;

    // Hex value of the key at index r*4+c
    int keymap_tb [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

    keypad_scanner_if intf ();

    keypad_scanner #(
        .COL_DWELL      (8),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk (clk),
        .res (res),
        .bus (intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        intf.rows = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!intf.cols[c] && pressed[r*4+c]) intf.rows[r] = 1'b0;
            end
        end
    end

    initial strobe_cnt = 0;
    always @(negedge clk) begin
        if (intf.key_strobe === 1'b1) strobe_cnt = strobe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [0:15] onehot(input int n);
        logic [0:15] v;
        v    = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    // Advance to the next cycle showing cols idle (the cycle keys updates)
    task automatic wait_eval();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (intf.cols == 4'b1111) return;
        end
        check("eval_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [15:0] kbit(input int r, input int c);
        logic [15:0] v;
        v          = '0;
        v[r*4 + c] = 1'b1;
        return v;
    endfunction

    logic [3:0]  exp_cols;
    logic [0:15] covered;
    int s0;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pressed  = '0;
        res      = 1'b0;

        // 1. Reset values, then idle sweeps with exact column timing
        repeat (3) @(negedge clk);
        check("rst_cols",   32'(intf.cols), 32'h0000000F);
        check("rst_keys",   32'(intf.keys), 32'h0);
        check("rst_strobe", 32'(intf.key_strobe), 32'h0);
        s0  = strobe_cnt;
        res = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 330; k++) begin
            @(negedge clk);
            case (k % 33)
                0,1,2,3,4,5,6,7:         exp_cols = 4'b1110;
                8,9,10,11,12,13,14,15:   exp_cols = 4'b1101;
                16,17,18,19,20,21,22,23: exp_cols = 4'b1011;
                32:                      exp_cols = 4'b1111;
                default:                 exp_cols = 4'b0111;
            endcase
            check("idle_cols", 32'(intf.cols), 32'(exp_cols));
            if (k % 33 == 32) check("idle_keys", 32'(intf.keys), 32'h0);
        end
        check("idle_strobe_cnt", 32'(strobe_cnt - s0), 32'd0);

        // 2. Hold "6" (r1,c2) for 8 sweeps, then release
        s0      = strobe_cnt;
        pressed = kbit(1, 2);
        wait_eval(); check("k6_eval1", 32'(intf.keys), 32'h0);
        wait_eval(); check("k6_eval2", 32'(intf.keys), 32'h0);
        wait_eval(); check("k6_eval3", 32'(intf.keys), 32'h0200);
        check("k6_strobe_at_eval3", 32'(intf.key_strobe), 32'h1);
        for (int s = 4; s <= 8; s++) begin
            wait_eval(); check("k6_hold", 32'(intf.keys), 32'h0200);
        end
        pressed = '0;
        wait_eval(); check("k6_rel_eval1", 32'(intf.keys), 32'h0200);
        wait_eval();
        wait_eval(); check("k6_rel_eval3", 32'(intf.keys), 32'h0);
        check("k6_strobe_cnt", 32'(strobe_cnt - s0), 32'd1);

        // 3. Bounce "E" (r3,c2) every sweep for 6 sweeps, then hold
        s0 = strobe_cnt;
        for (int s = 0; s < 6; s++) begin
            pressed = (s % 2 == 0) ? kbit(3, 2) : 16'h0;
            wait_eval(); check("bounce_keys", 32'(intf.keys), 32'h0);
        end
        pressed = kbit(3, 2);
        wait_eval(); check("e_eval1", 32'(intf.keys), 32'h0);
        wait_eval(); check("e_eval2", 32'(intf.keys), 32'h0);
        wait_eval(); check("e_eval3", 32'(intf.keys), 32'h0002);
        wait_eval(); check("e_eval4", 32'(intf.keys), 32'h0002);
        pressed = '0;
        repeat (3) wait_eval();
        check("e_release", 32'(intf.keys), 32'h0);
        check("e_strobe_cnt", 32'(strobe_cnt - s0), 32'd1);

        // 4. "1" held, then "A" added, then "1" released
        s0      = strobe_cnt;
        pressed = kbit(0, 0);
        repeat (3) wait_eval();
        check("k1_on", 32'(intf.keys), 32'h4000);
        pressed = kbit(0, 0) | kbit(0, 3);
        for (int s = 0; s < 4; s++) begin
            wait_eval(); check("multi_hold", 32'(intf.keys), 32'h4000);
        end
        pressed = kbit(0, 3);
        wait_eval(); check("to_a_eval1", 32'(intf.keys), 32'h4000);
        wait_eval(); check("to_a_eval2", 32'(intf.keys), 32'h4000);
        wait_eval(); check("to_a_eval3", 32'(intf.keys), 32'h0020);
        check("to_a_strobe_cnt", 32'(strobe_cnt - s0), 32'd1);
        pressed = '0;
        repeat (3) wait_eval();
        check("a_release", 32'(intf.keys), 32'h0);

        // 5. Reset mid-sweep with "9" (r2,c2) reported
        pressed = kbit(2, 2);
        repeat (3) wait_eval();
        check("k9_on", 32'(intf.keys), 32'h0040);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (intf.cols == 4'b1011) break;
        end
        check("k9_col2_seen", 32'(intf.cols), 32'h0000000B);
        repeat (2) @(negedge clk);
        #1 res = 1'b0;
        #1;
        check("midrst_keys",   32'(intf.keys), 32'h0);
        check("midrst_strobe", 32'(intf.key_strobe), 32'h0);
        check("midrst_cols",   32'(intf.cols), 32'h0000000F);
        repeat (2) @(negedge clk);
        res = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("restart_col0", 32'(intf.cols), 32'h0000000E);
        wait_eval(); check("k9r_eval1", 32'(intf.keys), 32'h0);
        wait_eval(); check("k9r_eval2", 32'(intf.keys), 32'h0);
        wait_eval(); check("k9r_eval3", 32'(intf.keys), 32'h0040);
        check("k9r_strobe", 32'(intf.key_strobe), 32'h1);
        pressed = '0;
        repeat (3) wait_eval();
        check("k9_release", 32'(intf.keys), 32'h0);

        // 6. Every key alone, checked against the bench keymap
        s0      = strobe_cnt;
        covered = '0;
        for (int idx = 0; idx < 16; idx++) begin
            pressed = kbit(idx / 4, idx % 4);
            wait_eval(); check("map_eval1", 32'(intf.keys), 32'h0);
            wait_eval();
            wait_eval(); check("map_eval3", 32'(intf.keys), 32'(onehot(keymap_tb[idx])));
            if (intf.keys == onehot(keymap_tb[idx])) covered = covered | intf.keys;
            wait_eval(); check("map_eval4", 32'(intf.keys), 32'(onehot(keymap_tb[idx])));
            pressed = '0;
            repeat (3) wait_eval();
            check("map_release", 32'(intf.keys), 32'h0);
        end
        check("map_coverage", 32'(covered), 32'h0000FFFF);
        check("map_strobe_cnt", 32'(strobe_cnt - s0), 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
